// File: rtl/noc_vc_port_if.sv
// Link bundle for the virtual-channel router input port: the upstream flit/credit
// side driven by the link receiver, and the outgoing flit/credit side driven by the port.
interface noc_vc_port_if #(
    parameter int DATA_W = 16,
    parameter int NUM_VC = 2
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic [VC_W-1:0]   vc_i;
    logic [NUM_VC-1:0] credit_i;
    logic              enable_o;
    logic [DATA_W-1:0] data_o;
    logic [VC_W-1:0]   vc_o;
    logic [NUM_VC-1:0] credit_o;
    logic              err_o;

    modport slave (
        input  valid_i, data_i, vc_i, credit_i,
        output enable_o, data_o, vc_o, credit_o, err_o
    );

    modport master (
        output valid_i, data_i, vc_i, credit_i,
        input  enable_o, data_o, vc_o, credit_o, err_o
    );
endinterface

// File: rtl/noc_vc_port.sv
// Credit-based router input port: per-VC flit FIFOs, per-VC downstream credit counters,
// round-robin arbitration onto one registered output link, one upstream credit per pop.
module noc_vc_port #(
    parameter int DATA_W     = 16,
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4,
    parameter int DS_CREDITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    noc_vc_port_if.slave link
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CRD_W = $clog2(DS_CREDITS + 1);

    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [OCC_W-1:0]  occ [NUM_VC];
    logic [CRD_W-1:0]  crd [NUM_VC];
    logic [VC_W-1:0]   rr_ptr;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [VC_W-1:0]   vc_p1;
    logic [NUM_VC-1:0] credit_p1;
    logic              err_q;

    logic              wr_ok;
    logic              wr_err;
    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] crd_ovf;
    logic [CRD_W-1:0]  crd_nxt [NUM_VC];
    logic              gnt_vld;
    logic [VC_W-1:0]   gnt;
    logic [VC_W-1:0]   cand;

    // Returns {overflow, next count}; a grant and a return in the same cycle cancel out,
    // and a return with the counter already full saturates and flags overflow.
    function automatic logic [CRD_W:0] sat_credit(input logic [CRD_W-1:0] cur,
                                                  input logic inc, input logic dec);
        logic [CRD_W:0] res;
        res = {1'b0, cur};
        if (inc && !dec) begin
            if (cur >= CRD_W'(DS_CREDITS)) res = {1'b1, cur};
            else                           res = {1'b0, cur + 1'b1};
        end else if (dec && !inc) begin
            res = {1'b0, cur - 1'b1};
        end
        return res;
    endfunction

    // Fullness is judged on the pre-edge occupancy, so a full FIFO being popped still drops.
    always_comb begin
        wr_ok  = 1'b0;
        wr_err = 1'b0;
        if (link.valid_i) begin
            if ((int'(link.vc_i) < NUM_VC) && (occ[link.vc_i] != OCC_W'(DEPTH))) wr_ok = 1'b1;
            else                                                                  wr_err = 1'b1;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            elig[v] = (occ[v] != '0) && (crd[v] != '0);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand = VC_W'((int'(rr_ptr) + i) % NUM_VC);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            push[v] = wr_ok && (link.vc_i == VC_W'(v));
            pop[v]  = gnt_vld && (gnt == VC_W'(v));
            {crd_ovf[v], crd_nxt[v]} = sat_credit(crd[v], link.credit_i[v], pop[v]);
        end
    end

    // Flit storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[link.vc_i][wr_ptr[link.vc_i]] <= link.data_i;
    end

    // ---- stage p1: registered output link ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                occ[v]    <= '0;
                crd[v]    <= CRD_W'(DS_CREDITS);
            end
            rr_ptr    <= '0;
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            vc_p1     <= '0;
            credit_p1 <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                if (push[v] && !pop[v])      occ[v] <= occ[v] + 1'b1;
                else if (pop[v] && !push[v]) occ[v] <= occ[v] - 1'b1;
                crd[v] <= crd_nxt[v];
            end
            vld_p1    <= gnt_vld;
            credit_p1 <= pop;
            if (gnt_vld) begin
                data_p1 <= mem[gnt][rd_ptr[gnt]];
                vc_p1   <= gnt;
                rr_ptr  <= VC_W'((int'(gnt) + 1) % NUM_VC);
            end
            if (wr_err || (|crd_ovf)) err_q <= 1'b1;
        end
    end

    assign link.enable_o = vld_p1;
    assign link.data_o   = data_p1;
    assign link.vc_o     = vc_p1;
    assign link.credit_o = credit_p1;
    assign link.err_o    = err_q;
endmodule

// File: tb/tb_noc_vc_port.sv
// Bench for noc_vc_port: cycle-exact vector table plus scoreboarded multi-cycle sequences.
module tb_noc_vc_port;
    localparam int DATA_W     = 16;
    localparam int NUM_VC     = 2;
    localparam int DEPTH      = 4;
    localparam int DS_CREDITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    int                out_vc_log[$];
    int                out_cyc_log[$];
    logic [DATA_W-1:0] mon_e;
    logic              mon_have;
    logic [NUM_VC-1:0] mon_cr;
    int                rel_cyc;

    typedef struct {
        logic        valid;
        logic        vc;
        logic [15:0] data;
        logic [1:0]  credit;
        logic        en;
        logic        ovc;
        logic [15:0] odata;
        logic [1:0]  ocredit;
        logic        err;
    } vec_t;
    vec_t tbl[10];

    noc_vc_port_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) link ();

    noc_vc_port #(
        .DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .DS_CREDITS(DS_CREDITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .link(link)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] outs();
        return {11'b0, link.err_o, link.enable_o, link.vc_o, link.credit_o, link.data_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int vc, input logic [15:0] d, input bit accept);
        link.valid_i = 1'b1;
        link.vc_i    = vc[0];
        link.data_i  = d;
        if (accept) begin
            if (vc == 0) exp_q0.push_back(d);
            else         exp_q1.push_back(d);
        end
        step();
        link.valid_i = 1'b0;
    endtask

    task automatic credit(input logic [1:0] c);
        link.credit_i = c;
        step();
        link.credit_i = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, exp_q0.size() + exp_q1.size(), 0);
    endtask

    // Scoreboard: every flit on the output link must be the oldest expected flit of its VC.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                if (link.enable_o) begin
                    mon_have = 1'b0;
                    mon_e    = '0;
                    if (link.vc_o == 1'b0 && exp_q0.size() > 0) begin
                        mon_e = exp_q0.pop_front();
                        mon_have = 1'b1;
                    end else if (link.vc_o == 1'b1 && exp_q1.size() > 0) begin
                        mon_e = exp_q1.pop_front();
                        mon_have = 1'b1;
                    end
                    mon_cr = (link.vc_o == 1'b0) ? 2'b01 : 2'b10;
                    checks++;
                    if (!mon_have || link.data_o !== mon_e || link.credit_o !== mon_cr) begin
                        errors++;
                        $display("FAIL flit_out: vc=%0d data=%h credit=%b, expected data=%h credit=%b (flit expected=%0d)",
                                 link.vc_o, link.data_o, link.credit_o, mon_e, mon_cr, mon_have);
                    end
                    out_vc_log.push_back(int'(link.vc_o));
                    out_cyc_log.push_back(cyc);
                end else begin
                    checks++;
                    if (link.credit_o !== '0) begin
                        errors++;
                        $display("FAIL idle_credit: credit_o=%b, expected 00", link.credit_o);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        link.valid_i  = 1'b0;
        link.vc_i     = '0;
        link.data_i   = '0;
        link.credit_i = '0;

        //             valid vc  data      cr     en  ovc odata     ocr    err
        tbl[0] = '{1'b1, 1'b1, 16'hA5A5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'hA5A5, 2'b10, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hA5A5, 2'b00, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h1111, 2'b00, 1'b0, 1'b1, 16'hA5A5, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'h2222, 2'b00, 1'b1, 1'b0, 16'h1111, 2'b01, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2222, 2'b10, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h2222, 2'b00, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h2222, 2'b00, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b1, 16'h2222, 2'b00, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h2222, 2'b00, 1'b0};

        #1 rst = 1'b0;
        #11;
        chk("reset_outputs", outs(), 32'h0);
        step();
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            link.valid_i  = tbl[i].valid;
            link.vc_i     = tbl[i].vc;
            link.data_i   = tbl[i].data;
            link.credit_i = tbl[i].credit;
            if (tbl[i].valid) begin
                if (tbl[i].vc == 1'b0) exp_q0.push_back(tbl[i].data);
                else                   exp_q1.push_back(tbl[i].data);
            end
            step();
            chk($sformatf("vec%0d", i), outs(),
                {11'b0, tbl[i].err, tbl[i].en, tbl[i].ovc, tbl[i].ocredit, tbl[i].odata});
        end
        link.valid_i  = 1'b0;
        link.credit_i = '0;

        // Alternating traffic uses up all credits on both VCs and leaves the pointer at VC0.
        out_vc_log.delete();
        out_cyc_log.delete();
        for (int i = 0; i < 8; i++) send(i % 2, 16'(32'h3000 + i), 1'b1);
        wait_drain("rr_alt_drain", 20);
        chk("rr_alt_count", out_vc_log.size(), 8);
        if (out_vc_log.size() == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("rr_alt_vc%0d", i), out_vc_log[i], i % 2);

        // Three flits per VC wait on zero credits; returning credits must interleave them.
        out_vc_log.delete();
        out_cyc_log.delete();
        for (int i = 0; i < 3; i++) send(0, 16'(32'h4000 + i), 1'b1);
        for (int i = 0; i < 3; i++) send(1, 16'(32'h4100 + i), 1'b1);
        step();
        chk("rr_stalled", out_vc_log.size(), 0);
        for (int i = 0; i < 3; i++) credit(2'b11);
        wait_drain("rr_drain", 20);
        chk("rr_count", out_vc_log.size(), 6);
        if (out_vc_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("rr_vc%0d", i), out_vc_log[i], i % 2);
            for (int i = 1; i < 6; i++)
                chk($sformatf("rr_back2back%0d", i), out_cyc_log[i] - out_cyc_log[i-1], 1);
        end

        // Credit stall on VC0.
        for (int i = 0; i < 4; i++) credit(2'b01);
        out_vc_log.delete();
        out_cyc_log.delete();
        for (int i = 0; i < 5; i++) send(0, 16'(32'h5000 + i), 1'b1);
        for (int n = 0; n < 20 && exp_q0.size() > 1; n++) step();
        repeat (5) step();
        chk("stall_held", exp_q0.size(), 1);
        chk("stall_count", out_vc_log.size(), 4);
        out_vc_log.delete();
        out_cyc_log.delete();
        rel_cyc = cyc;
        credit(2'b01);
        repeat (2) step();
        chk("stall_release_count", out_vc_log.size(), 1);
        if (out_vc_log.size() == 1) chk("stall_release_latency", out_cyc_log[0] - rel_cyc, 2);

        // Overflow of VC1 while its credit counter is empty.
        for (int i = 0; i < 4; i++) send(1, 16'(32'h6000 + i), 1'b1);
        chk("overflow_no_err_yet", link.err_o, 0);
        send(1, 16'h6004, 1'b0);
        chk("overflow_err", link.err_o, 1);
        repeat (3) step();
        chk("overflow_held", exp_q1.size(), 4);
        for (int i = 0; i < 4; i++) credit(2'b10);
        wait_drain("overflow_drain", 20);
        credit(2'b10);
        repeat (4) step();
        chk("overflow_sticky", link.err_o, 1);

        // Asynchronous reset while a flit is on the output link.
        send(1, 16'h7000, 1'b1);
        send(1, 16'h7001, 1'b0);
        chk("pre_reset_enable", link.enable_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("reset_async", outs(), 32'h0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) send(i % 2, 16'(32'h8000 + i), 1'b1);
        wait_drain("post_reset_drain", 20);
        chk("post_reset_err", link.err_o, 0);

        // Credit over-return straight after reset.
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        credit(2'b01);
        chk("over_return_err", link.err_o, 1);
        out_vc_log.delete();
        out_cyc_log.delete();
        for (int i = 0; i < 5; i++) send(0, 16'(32'h9000 + i), i < 4);
        repeat (6) step();
        wait_drain("over_return_drain", 10);
        chk("over_return_cap", out_vc_log.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
